// File: rtl/oai33_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : oai33_vector_sequencer
// Description : Exhaustive functional sequencer for a 6-input OAI33 cell.
//               Sweeps all 64 input vectors, lets each settle for a
//               programmable number of cycles, samples ZN and compares it
//               against the golden OAI33 function. Reports the pass flag,
//               the mismatch count and the lowest failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module oai33_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    input  logic       ZN_DUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [6:0] ERR_CNT,
    output logic [5:0] FIRST_FAIL,
    output logic       FIRST_FAIL_VLD
);

    // The settle counter is 4 bits wide, so only 1..15 can be represented.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("oai33_vector_sequencer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] C_SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0] C_LAST_VEC      = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [5:0] r_vec;
    logic [5:0] r_drive;
    logic [3:0] r_settle_cnt;

    logic       w_golden;
    logic       w_mismatch;
    logic [6:0] w_err_next;

    // Drive pins mirror a dedicated register that is zero whenever not busy.
    assign {B3, B2, B1, A3, A2, A1} = r_drive;

    // Golden OAI33 response for the current vector and the resulting error count.
    assign w_golden   = ~((r_vec[0] | r_vec[1] | r_vec[2]) & (r_vec[3] | r_vec[4] | r_vec[5]));
    assign w_mismatch = (ZN_DUT != w_golden);
    assign w_err_next = w_mismatch ? (ERR_CNT + 7'd1) : ERR_CNT;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_vec          <= 6'd0;
            r_drive        <= 6'd0;
            r_settle_cnt   <= 4'd0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            ERR_CNT        <= 7'd0;
            FIRST_FAIL     <= 6'd0;
            FIRST_FAIL_VLD <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START && !ABORT) begin
                        r_state        <= ST_SETTLE;
                        r_vec          <= 6'd0;
                        r_drive        <= 6'd0;
                        r_settle_cnt   <= C_SETTLE_RELOAD;
                        BUSY           <= 1'b1;
                        PASS           <= 1'b0;
                        ERR_CNT        <= 7'd0;
                        FIRST_FAIL     <= 6'd0;
                        FIRST_FAIL_VLD <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (ABORT) begin
                        r_state <= ST_IDLE;
                        r_drive <= 6'd0;
                        BUSY    <= 1'b0;
                    end else if (r_settle_cnt == 4'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    // The compare result is recorded even when aborting this cycle.
                    ERR_CNT <= w_err_next;
                    if (w_mismatch && !FIRST_FAIL_VLD) begin
                        FIRST_FAIL     <= r_vec;
                        FIRST_FAIL_VLD <= 1'b1;
                    end
                    if (ABORT) begin
                        r_state <= ST_IDLE;
                        r_drive <= 6'd0;
                        BUSY    <= 1'b0;
                    end else if (r_vec == C_LAST_VEC) begin
                        r_state <= ST_DONE;
                        r_drive <= 6'd0;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        PASS    <= (w_err_next == 7'd0);
                    end else begin
                        r_state      <= ST_SETTLE;
                        r_vec        <= r_vec + 6'd1;
                        r_drive      <= r_vec + 6'd1;
                        r_settle_cnt <= C_SETTLE_RELOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oai33_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oai33_vector_sequencer
// Description : Directed bench for oai33_vector_sequencer with a queue of
//               expected drive vectors and a behavioural OAI33 cell model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oai33_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start2, abort2, start1, abort1;
    int   mode2;   // 0: good cell model, 1: ZN stuck at 1, 2: ZN stuck at 0

    logic d2_a1, d2_a2, d2_a3, d2_b1, d2_b2, d2_b3, zn2;
    logic busy2, done2, pass2, vld2;
    logic [6:0] err2;
    logic [5:0] ff2;
    logic [5:0] drv2;

    logic d1_a1, d1_a2, d1_a3, d1_b1, d1_b2, d1_b3, zn1;
    logic busy1, done1, pass1, vld1;
    logic [6:0] err1;
    logic [5:0] ff1;
    logic [5:0] drv1;

    assign drv2 = {d2_b3, d2_b2, d2_b1, d2_a3, d2_a2, d2_a1};
    assign drv1 = {d1_b3, d1_b2, d1_b1, d1_a3, d1_a2, d1_a1};

    // Cell under test models
    assign zn2 = (mode2 == 0) ? ~((d2_a1 | d2_a2 | d2_a3) & (d2_b1 | d2_b2 | d2_b3))
                              : (mode2 == 1);
    assign zn1 = ~((d1_a1 | d1_a2 | d1_a3) & (d1_b1 | d1_b2 | d1_b3));

    oai33_vector_sequencer #(.SETTLE_CYCLES(2)) u_dut2 (
        .CLK(clk), .RST(rst), .START(start2), .ABORT(abort2),
        .A1(d2_a1), .A2(d2_a2), .A3(d2_a3), .B1(d2_b1), .B2(d2_b2), .B3(d2_b3),
        .ZN_DUT(zn2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FIRST_FAIL(ff2), .FIRST_FAIL_VLD(vld2)
    );

    oai33_vector_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start1), .ABORT(abort1),
        .A1(d1_a1), .A2(d1_a2), .A3(d1_a3), .B1(d1_b1), .B2(d1_b2), .B3(d1_b3),
        .ZN_DUT(zn1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FIRST_FAIL(ff1), .FIRST_FAIL_VLD(vld1)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [5:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run on the SETTLE_CYCLES=2 instance, checking every held vector.
    task automatic run2(input int mode, input int e_err, input int e_ff,
                        input int e_vld, input int e_pass);
        int cyc;
        logic [5:0] e;
        mode2  = mode;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        sb.delete();
        for (int c = 0; c < 192; c++) sb.push_back(6'(c / 3));
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 300) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("drive2", 32'(drv2), 32'(e));
                chk("busy2", 32'(busy2), 32'd1);
            end
            tick();
            cyc++;
        end
        chk("done_latency2", cyc, 192);
        chk("sb_empty2", sb.size(), 0);
        chk("busy_at_done2", 32'(busy2), 32'd0);
        chk("drive_at_done2", 32'(drv2), 32'd0);
        chk("pass2", 32'(pass2), e_pass);
        chk("err2", 32'(err2), e_err);
        chk("ff2", 32'(ff2), e_ff);
        chk("vld2", 32'(vld2), e_vld);
        tick();
        chk("done_pulse2", 32'(done2), 32'd0);
        chk("err_hold2", 32'(err2), e_err);
        chk("pass_hold2", 32'(pass2), e_pass);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [5:0] e;

        rst = 1'b1; start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        mode2 = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_done", 32'(done2), 32'd0);
        chk("rst_pass", 32'(pass2), 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_ff", 32'(ff2), 32'd0);
        chk("rst_vld", 32'(vld2), 32'd0);
        chk("rst_drive", 32'(drv2), 32'd0);

        // Good cell, ZN stuck at 1, ZN stuck at 0
        run2(0, 0, 0, 0, 1);
        run2(1, 49, 9, 1, 0);
        run2(2, 15, 0, 1, 0);

        // START together with ABORT in IDLE: stays idle, results untouched
        start2 = 1'b1; abort2 = 1'b1;
        tick();
        start2 = 1'b0; abort2 = 1'b0;
        chk("start_abort_busy", 32'(busy2), 32'd0);
        tick();
        chk("start_abort_busy2", 32'(busy2), 32'd0);
        chk("start_abort_err", 32'(err2), 32'd15);

        // ABORT while vector 20 is settling, ZN stuck at 1
        mode2 = 1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (60) tick();
        chk("abort_pre_drive", 32'(drv2), 32'd20);
        chk("abort_pre_busy", 32'(busy2), 32'd1);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("abort_busy", 32'(busy2), 32'd0);
        chk("abort_drive", 32'(drv2), 32'd0);
        chk("abort_pass", 32'(pass2), 32'd0);
        chk("abort_err", 32'(err2), 32'd10);
        chk("abort_ff", 32'(ff2), 32'd9);
        chk("abort_vld", 32'(vld2), 32'd1);
        seen = 0;
        repeat (200) begin
            tick();
            if (done2 === 1'b1) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        // SETTLE_CYCLES=1 instance with an ignored START mid-run
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        sb.delete();
        for (int c = 0; c < 128; c++) sb.push_back(6'(c / 2));
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 250) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("drive1", 32'(drv1), 32'(e));
            end
            start1 = (cyc == 50);
            tick();
            cyc++;
        end
        start1 = 1'b0;
        chk("done_latency1", cyc, 128);
        chk("pass1", 32'(pass1), 32'd1);
        chk("err1", 32'(err1), 32'd0);
        chk("vld1", 32'(vld1), 32'd0);
        tick();
        chk("idle_after1", 32'(busy1), 32'd0);

        // Reset in the middle of a failing run, then a clean full run
        mode2 = 1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (100) tick();
        chk("midrun_err", 32'(err2), 32'd21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy2), 32'd0);
        chk("midrst_drive", 32'(drv2), 32'd0);
        chk("midrst_err", 32'(err2), 32'd0);
        chk("midrst_ff", 32'(ff2), 32'd0);
        chk("midrst_vld", 32'(vld2), 32'd0);
        chk("midrst_pass", 32'(pass2), 32'd0);
        chk("midrst_done", 32'(done2), 32'd0);
        run2(0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
